// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch
// Description : Instruction-fetch stage. Fetches the word at the PC's current
//               address over a req/ack memory handshake, stalls the PC until
//               that word is captured, and loads the IF/ID register. A
//               one-entry skid buffer absorbs decode back-pressure; a jump
//               flush discards in-flight and buffered instructions.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst      : clock, asynchronous active-high reset
//   i_pc_addr     : current fetch address from the PC
//   o_pc_stall    : hold the PC (PC stall input)
//   i_flush       : jump taken this cycle
//   o_imem_req    : fetch request
//   o_imem_addr   : fetch address, stable until ack
//   i_imem_ack    : one-cycle response strobe
//   i_imem_rdata  : instruction word, valid with ack
//   i_id_stall    : decode cannot accept a new IF/ID entry
//   o_ifid_valid  : IF/ID holds a live instruction
//   o_ifid_pc     : address of the held instruction
//   o_ifid_pc4    : o_ifid_pc + 4
//   o_ifid_instr  : held instruction (NOP_INSTR when invalid)
// ============================================================================
module inst_fetch #(
  parameter int                    WORD_WIDTH = 32,
  parameter logic [WORD_WIDTH-1:0] NOP_INSTR  = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WORD_WIDTH-1:0] i_pc_addr,
  output logic                  o_pc_stall,
  input  logic                  i_flush,
  output logic                  o_imem_req,
  output logic [WORD_WIDTH-1:0] o_imem_addr,
  input  logic                  i_imem_ack,
  input  logic [WORD_WIDTH-1:0] i_imem_rdata,
  input  logic                  i_id_stall,
  output logic                  o_ifid_valid,
  output logic [WORD_WIDTH-1:0] o_ifid_pc,
  output logic [WORD_WIDTH-1:0] o_ifid_pc4,
  output logic [WORD_WIDTH-1:0] o_ifid_instr
);

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_HOLD = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic                  r_ifid_valid;
  logic [WORD_WIDTH-1:0] r_ifid_pc;
  logic [WORD_WIDTH-1:0] r_ifid_pc4;
  logic [WORD_WIDTH-1:0] r_ifid_instr;

  logic                  r_skid_valid;
  logic [WORD_WIDTH-1:0] r_skid_pc;
  logic [WORD_WIDTH-1:0] r_skid_pc4;
  logic [WORD_WIDTH-1:0] r_skid_instr;

  logic [WORD_WIDTH-1:0] r_drop_addr;

  logic                  w_out_free;
  logic                  w_fetch_ok;
  logic                  w_load_ifid_mem;
  logic                  w_load_skid;
  logic                  w_load_ifid_skid;
  logic                  w_bubble;
  logic                  w_start_drop;
  logic [WORD_WIDTH-1:0] w_pc_plus4;

  assign w_out_free       = !r_ifid_valid || !i_id_stall;
  assign w_pc_plus4       = i_pc_addr + WORD_WIDTH'(4);

  // A word returned in REQ is kept only when no jump is being taken.
  assign w_fetch_ok       = (r_state == ST_REQ) && i_imem_ack && !i_flush;
  assign w_load_ifid_mem  = w_fetch_ok && w_out_free;
  assign w_load_skid      = w_fetch_ok && !w_out_free;
  assign w_load_ifid_skid = (r_state == ST_HOLD) && r_skid_valid && !i_flush && !i_id_stall;
  assign w_bubble         = (r_state == ST_REQ) && !i_imem_ack && !i_flush && !i_id_stall;
  // The pending request cannot be withdrawn, so its address is remembered
  // while the PC moves on to the jump target.
  assign w_start_drop     = (r_state == ST_REQ) && i_flush && !i_imem_ack;

  assign o_imem_req   = (r_state == ST_REQ) || (r_state == ST_DROP);
  assign o_imem_addr  = (r_state == ST_DROP) ? r_drop_addr : i_pc_addr;
  // Acks during reset must not advance the PC.
  assign o_pc_stall   = rst || !(i_flush || ((r_state == ST_REQ) && i_imem_ack));

  assign o_ifid_valid = r_ifid_valid;
  assign o_ifid_pc    = r_ifid_pc;
  assign o_ifid_pc4   = r_ifid_pc4;
  assign o_ifid_instr = r_ifid_instr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_REQ;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_REQ: begin
        if (w_start_drop) begin
          w_state_nxt = ST_DROP;
        end else if (w_load_skid) begin
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (i_flush || !i_id_stall) begin
          w_state_nxt = ST_REQ;
        end
      end
      ST_DROP: begin
        // A further flush leaves the stale request outstanding.
        if (!i_flush && i_imem_ack) begin
          w_state_nxt = ST_REQ;
        end
      end
      default: w_state_nxt = ST_REQ;
    endcase
  end

  // IF/ID register; the instruction word is forced to NOP whenever the
  // entry is invalidated so the output needs no combinational mux.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ifid_valid <= 1'b0;
      r_ifid_pc    <= '0;
      r_ifid_pc4   <= '0;
      r_ifid_instr <= NOP_INSTR;
    end else if (i_flush || w_bubble) begin
      r_ifid_valid <= 1'b0;
      r_ifid_instr <= NOP_INSTR;
    end else if (w_load_ifid_mem) begin
      r_ifid_valid <= 1'b1;
      r_ifid_pc    <= i_pc_addr;
      r_ifid_pc4   <= w_pc_plus4;
      r_ifid_instr <= i_imem_rdata;
    end else if (w_load_ifid_skid) begin
      r_ifid_valid <= 1'b1;
      r_ifid_pc    <= r_skid_pc;
      r_ifid_pc4   <= r_skid_pc4;
      r_ifid_instr <= r_skid_instr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_skid_valid <= 1'b0;
      r_skid_pc    <= '0;
      r_skid_pc4   <= '0;
      r_skid_instr <= NOP_INSTR;
    end else if (i_flush || w_load_ifid_skid) begin
      r_skid_valid <= 1'b0;
    end else if (w_load_skid) begin
      r_skid_valid <= 1'b1;
      r_skid_pc    <= i_pc_addr;
      r_skid_pc4   <= w_pc_plus4;
      r_skid_instr <= i_imem_rdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drop_addr <= '0;
    end else if (w_start_drop) begin
      r_drop_addr <= i_pc_addr;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_fetch
// Description : Directed self-checking bench for inst_fetch. Contains a PC
//               model (stall/jump) and a fixed-latency instruction memory
//               whose data is address ^ 32'hDEAD_0000.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_fetch;

  localparam logic [31:0] PC_INIT = 32'h0;
  localparam logic [31:0] NOP     = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        id_stall;
  logic [31:0] jump_addr;
  logic [31:0] pc;
  logic        pc_stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        ifid_valid;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc4;
  logic [31:0] ifid_instr;
  int          mem_lat;
  int          mem_wait;
  int          n_checks;
  int          n_errors;

  inst_fetch #(.WORD_WIDTH(32), .NOP_INSTR(NOP)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_pc_addr   (pc),
    .o_pc_stall  (pc_stall),
    .i_flush     (flush),
    .o_imem_req  (imem_req),
    .o_imem_addr (imem_addr),
    .i_imem_ack  (imem_ack),
    .i_imem_rdata(imem_rdata),
    .i_id_stall  (id_stall),
    .o_ifid_valid(ifid_valid),
    .o_ifid_pc   (ifid_pc),
    .o_ifid_pc4  (ifid_pc4),
    .o_ifid_instr(ifid_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PC: stall has priority over jump.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc <= PC_INIT;
    else if (!pc_stall) pc <= flush ? jump_addr : pc + 32'd4;
  end

  // Memory: ack after mem_lat waiting cycles of a request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) mem_wait <= 0;
    else if (imem_req && !imem_ack) mem_wait <= mem_wait + 1;
    else mem_wait <= 0;
  end
  assign imem_ack   = imem_req && (mem_wait >= mem_lat);
  assign imem_rdata = imem_addr ^ 32'hDEAD_0000;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; id_stall = 1'b0; jump_addr = 32'h0; mem_lat = 0;
    #1;
    n_checks++; if (ifid_valid !== 1'b0) begin n_errors++; $display("FAIL rst_valid: got %b want 0", ifid_valid); end
    n_checks++; if (ifid_pc !== 32'h0) begin n_errors++; $display("FAIL rst_pc: got %h want 0", ifid_pc); end
    n_checks++; if (ifid_pc4 !== 32'h0) begin n_errors++; $display("FAIL rst_pc4: got %h want 0", ifid_pc4); end
    n_checks++; if (ifid_instr !== NOP) begin n_errors++; $display("FAIL rst_instr: got %h want %h", ifid_instr, NOP); end
    step(); step();
    n_checks++; if (imem_req !== 1'b1) begin n_errors++; $display("FAIL rst_req: got %b want 1", imem_req); end
    n_checks++; if (imem_addr !== PC_INIT) begin n_errors++; $display("FAIL rst_addr: got %h want %h", imem_addr, PC_INIT); end
    // memory acks during reset; the PC must stay held
    n_checks++; if (pc_stall !== 1'b1) begin n_errors++; $display("FAIL rst_stall: got %b want 1", pc_stall); end
    n_checks++; if (ifid_valid !== 1'b0) begin n_errors++; $display("FAIL rst_ack_ignored: got %b want 0", ifid_valid); end
    rst = 1'b0;
    #1;
  endtask

  task automatic test_zero_wait();
    n_checks++; if (pc_stall !== 1'b0) begin n_errors++; $display("FAIL zw_stall0: got %b want 0", pc_stall); end
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++; if (ifid_valid !== 1'b1) begin n_errors++; $display("FAIL zw_valid[%0d]: got %b want 1", i, ifid_valid); end
      n_checks++; if (ifid_pc !== 32'(4 * i)) begin n_errors++; $display("FAIL zw_pc[%0d]: got %h want %h", i, ifid_pc, 32'(4 * i)); end
      n_checks++; if (ifid_pc4 !== 32'(4 * i + 4)) begin n_errors++; $display("FAIL zw_pc4[%0d]: got %h want %h", i, ifid_pc4, 32'(4 * i + 4)); end
      n_checks++; if (ifid_instr !== (32'(4 * i) ^ 32'hDEAD_0000)) begin n_errors++; $display("FAIL zw_instr[%0d]: got %h want %h", i, ifid_instr, 32'(4 * i) ^ 32'hDEAD_0000); end
      n_checks++; if (pc_stall !== 1'b0) begin n_errors++; $display("FAIL zw_stall[%0d]: got %b want 0", i, pc_stall); end
    end
  endtask

  task automatic test_wait();
    mem_lat = 2;
    #1;
    for (int i = 0; i < 2; i++) begin
      n_checks++; if (pc_stall !== 1'b1) begin n_errors++; $display("FAIL wait_stall[%0d]: got %b want 1", i, pc_stall); end
      n_checks++; if (imem_addr !== 32'h10) begin n_errors++; $display("FAIL wait_addr[%0d]: got %h want 00000010", i, imem_addr); end
      step();
      n_checks++; if (ifid_valid !== 1'b0) begin n_errors++; $display("FAIL wait_bubble[%0d]: got %b want 0", i, ifid_valid); end
      n_checks++; if (ifid_instr !== NOP) begin n_errors++; $display("FAIL wait_nop[%0d]: got %h want %h", i, ifid_instr, NOP); end
    end
    n_checks++; if (pc_stall !== 1'b0) begin n_errors++; $display("FAIL wait_ack_stall: got %b want 0", pc_stall); end
    step();
    n_checks++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'h10) begin n_errors++; $display("FAIL wait_pc: got %b/%h want 1/00000010", ifid_valid, ifid_pc); end
    n_checks++; if (ifid_instr !== 32'hDEAD_0010) begin n_errors++; $display("FAIL wait_instr: got %h want dead0010", ifid_instr); end
  endtask

  task automatic test_skid();
    mem_lat = 0;
    step(); step(); step(); step();  // 0x14, 0x18, 0x1c, 0x20
    n_checks++; if (ifid_pc !== 32'h20) begin n_errors++; $display("FAIL skid_pre_pc: got %h want 00000020", ifid_pc); end
    id_stall = 1'b1;
    step();  // ack for 0x24 lands in the skid buffer
    for (int i = 0; i < 2; i++) begin
      n_checks++; if (imem_req !== 1'b0) begin n_errors++; $display("FAIL skid_req[%0d]: got %b want 0", i, imem_req); end
      n_checks++; if (pc_stall !== 1'b1) begin n_errors++; $display("FAIL skid_stall[%0d]: got %b want 1", i, pc_stall); end
      n_checks++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'h20) begin n_errors++; $display("FAIL skid_hold[%0d]: got %b/%h want 1/00000020", i, ifid_valid, ifid_pc); end
      if (i == 0) step();
    end
    id_stall = 1'b0;
    step();
    n_checks++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'h24) begin n_errors++; $display("FAIL skid_out_pc: got %b/%h want 1/00000024", ifid_valid, ifid_pc); end
    n_checks++; if (ifid_instr !== 32'hDEAD_0024) begin n_errors++; $display("FAIL skid_out_instr: got %h want dead0024", ifid_instr); end
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h28) begin n_errors++; $display("FAIL skid_resume_addr: got %b/%h want 1/00000028", imem_req, imem_addr); end
    step();
    n_checks++; if (ifid_pc !== 32'h28) begin n_errors++; $display("FAIL skid_next_pc: got %h want 00000028", ifid_pc); end
  endtask

  task automatic test_drop();
    step();  // 0x2c
    mem_lat = 3;
    flush = 1'b1; jump_addr = 32'h100;
    #1;
    n_checks++; if (pc_stall !== 1'b0) begin n_errors++; $display("FAIL drop_flush_stall: got %b want 0", pc_stall); end
    step();
    flush = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h30) begin n_errors++; $display("FAIL drop_addr[%0d]: got %b/%h want 1/00000030", i, imem_req, imem_addr); end
      n_checks++; if (pc_stall !== 1'b1) begin n_errors++; $display("FAIL drop_stall[%0d]: got %b want 1", i, pc_stall); end
      n_checks++; if (ifid_valid !== 1'b0 || ifid_instr !== NOP) begin n_errors++; $display("FAIL drop_valid[%0d]: got %b/%h want 0/%h", i, ifid_valid, ifid_instr, NOP); end
      step();
    end
    n_checks++; if (ifid_valid !== 1'b0) begin n_errors++; $display("FAIL drop_discard: got %b want 0", ifid_valid); end
    mem_lat = 0;
    #1;
    n_checks++; if (imem_addr !== 32'h100) begin n_errors++; $display("FAIL drop_target_addr: got %h want 00000100", imem_addr); end
    step();
    n_checks++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'h100) begin n_errors++; $display("FAIL drop_target_pc: got %b/%h want 1/00000100", ifid_valid, ifid_pc); end
    n_checks++; if (ifid_instr !== 32'hDEAD_0100) begin n_errors++; $display("FAIL drop_target_instr: got %h want dead0100", ifid_instr); end
  endtask

  task automatic test_flush_ack();
    flush = 1'b1; jump_addr = 32'h200;  // ack for 0x104 arrives with the flush
    step();
    flush = 1'b0;
    #1;
    n_checks++; if (ifid_valid !== 1'b0) begin n_errors++; $display("FAIL fack_discard: got %b want 0", ifid_valid); end
    n_checks++; if (imem_addr !== 32'h200) begin n_errors++; $display("FAIL fack_addr: got %h want 00000200", imem_addr); end
    step();
    n_checks++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'h200 || ifid_instr !== 32'hDEAD_0200) begin n_errors++; $display("FAIL fack_target: got %b/%h/%h want 1/00000200/dead0200", ifid_valid, ifid_pc, ifid_instr); end
  endtask

  task automatic test_flush_hold();
    id_stall = 1'b1;
    step();  // 0x204 goes to the skid buffer
    n_checks++; if (imem_req !== 1'b0) begin n_errors++; $display("FAIL fhold_in_hold: got %b want 0", imem_req); end
    flush = 1'b1; jump_addr = 32'h300;
    #1;
    n_checks++; if (pc_stall !== 1'b0) begin n_errors++; $display("FAIL fhold_stall: got %b want 0", pc_stall); end
    step();
    flush = 1'b0; id_stall = 1'b0;
    #1;
    n_checks++; if (ifid_valid !== 1'b0 || ifid_instr !== NOP) begin n_errors++; $display("FAIL fhold_flushed: got %b/%h want 0/%h", ifid_valid, ifid_instr, NOP); end
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h300) begin n_errors++; $display("FAIL fhold_addr: got %b/%h want 1/00000300", imem_req, imem_addr); end
    step();
    n_checks++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'h300) begin n_errors++; $display("FAIL fhold_target: got %b/%h want 1/00000300", ifid_valid, ifid_pc); end
    step();
    n_checks++; if (ifid_pc !== 32'h304 || ifid_pc4 !== 32'h308) begin n_errors++; $display("FAIL fhold_next: got %h/%h want 00000304/00000308", ifid_pc, ifid_pc4); end
  endtask

  task automatic test_reset_drop();
    mem_lat = 5;
    flush = 1'b1; jump_addr = 32'h400;  // request for 0x308 still pending
    step();
    flush = 1'b0;
    step();
    n_checks++; if (imem_addr !== 32'h308 || pc !== 32'h400) begin n_errors++; $display("FAIL rdrop_in_drop: got %h/%h want 00000308/00000400", imem_addr, pc); end
    rst = 1'b1;
    #1;
    n_checks++; if (ifid_valid !== 1'b0 || ifid_pc !== 32'h0 || ifid_pc4 !== 32'h0 || ifid_instr !== NOP) begin n_errors++; $display("FAIL rdrop_async: got %b/%h/%h/%h want 0/0/0/%h", ifid_valid, ifid_pc, ifid_pc4, ifid_instr, NOP); end
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== PC_INIT) begin n_errors++; $display("FAIL rdrop_req: got %b/%h want 1/%h", imem_req, imem_addr, PC_INIT); end
    step();
    mem_lat = 0;
    rst = 1'b0;
    step();
    n_checks++; if (ifid_valid !== 1'b1 || ifid_pc !== PC_INIT || ifid_instr !== 32'hDEAD_0000) begin n_errors++; $display("FAIL rdrop_first: got %b/%h/%h want 1/%h/dead0000", ifid_valid, ifid_pc, ifid_instr, PC_INIT); end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    test_reset();
    test_zero_wait();
    test_wait();
    test_skid();
    test_drop();
    test_flush_ack();
    test_flush_hold();
    test_reset_drop();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/inst_fetch.md
# inst_fetch

Instruction-fetch stage between the program counter and the IF/ID boundary. It fetches the word at the PC's current address over a req/ack instruction-memory handshake and drives the PC's `stall` so the PC advances only when that word is captured. Fetched words go into the IF/ID pipeline register, with a one-entry skid buffer for decode back-pressure. Jump flushes discard in-flight and buffered instructions.

## Interface
- `WORD_WIDTH`, 32, address/instruction width.
- `NOP_INSTR`, 32'h0000_0000, value driven on `ifid_instr` whenever `ifid_valid`=0.

- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `pc_addr`  in  WORD_WIDTH  current fetch address from the PC (`nowaddr`).
- `pc_stall`  out  1  holds the PC; wired to the PC's `stall`.
- `flush`  in  1  jump taken this cycle; same signal as the PC's `pc_src` = jump.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  WORD_WIDTH  fetch address; stable while `imem_req`=1 until ack.
- `imem_ack`  in  1  one-cycle response strobe; may come in the request's first cycle.
- `imem_rdata`  in  WORD_WIDTH  instruction word, valid with `imem_ack`.
- `id_stall`  in  1  decode cannot accept a new IF/ID entry.
- `ifid_valid`  out  1  IF/ID holds a live instruction.
- `ifid_pc`  out  WORD_WIDTH  address of the held instruction.
- `ifid_pc4`  out  WORD_WIDTH  `ifid_pc`+4, modulo 2^WORD_WIDTH.
- `ifid_instr`  out  WORD_WIDTH  held instruction word.

## Operation
- States: REQ, HOLD, DROP. Only one fetch is outstanding at a time.
- `out_free` = !`ifid_valid` || !`id_stall`.
- `imem_req` = (state==REQ || state==DROP).
- `imem_addr` = `drop_addr` in DROP, otherwise `pc_addr`.
- `pc_stall` = !(flush || (state==REQ && imem_ack)).
- REQ:
  - ack, no flush, `out_free`: load IF/ID with {1, `pc_addr`, `pc_addr`+4, `imem_rdata`}. Stay in REQ.
  - ack, no flush, !`out_free`: load the skid buffer with the same tuple. Go to HOLD.
  - no ack, no flush: if !`id_stall`, set `ifid_valid`←0 (bubble).
  - flush with ack: discard the data. Stay in REQ.
  - flush without ack: `drop_addr`←`pc_addr`. Go to DROP.
- HOLD (`imem_req`=0, `pc_stall`=1):
  - !`id_stall`: move the skid buffer to IF/ID. Go to REQ.
  - flush: clear the skid buffer. Go to REQ.
- DROP: keep requesting `drop_addr` until ack, then discard the data and go to REQ. A flush in DROP keeps the state in DROP, and the PC takes the new target.
- Flush priority: flush beats `id_stall`. On a flush cycle, `ifid_valid`←0 and the skid buffer is invalidated.
- `imem_ack` is ignored in HOLD.
- When `ifid_valid`=0, `ifid_instr`=NOP_INSTR. `ifid_pc` and `ifid_pc4` hold their last values.

## Timing
- Reset values: state=REQ, `ifid_valid`=0, `ifid_pc`=0, `ifid_pc4`=0, `ifid_instr`=NOP_INSTR, skid buffer invalid, `drop_addr`=0.
- During reset: `imem_req`=1 and `imem_addr`=`pc_addr`. Any ack is ignored until `rst` falls.
- Reset mid-fetch or in DROP discards everything. The memory must tolerate an abandoned request.
- Zero-wait memory (ack in the request cycle): one instruction per cycle. `ifid_*` update on the clock edge that ends the ack cycle, and the PC advances on that same edge.
- N-cycle memory latency: the PC stalls for N cycles, and IF/ID shows bubbles if decode is draining.
- All IF/ID and state updates happen on the `posedge clk`. Outputs are combinational only in `imem_req`, `imem_addr` and `pc_stall`.
- `pc_stall` is low on every flush cycle so the PC loads `jumpaddr`, because the PC gives stall priority over jump.

## Test plan
- Zero-wait memory, PC_INIT=0, `id_stall`=0:
  - `ifid_pc` = 0, 4, 8, 12 on consecutive cycles.
  - `ifid_pc4` = `ifid_pc`+4.
  - `pc_stall` stays 0.
- Ack two cycles after the request at address 0x10:
  - `pc_stall`=1 for 2 cycles, then `ifid_pc`=0x10 with `imem_rdata`.
  - `ifid_valid`=0 during the wait.
- `id_stall`=1 while `ifid_pc`=0x20 and ack arrives for 0x24:
  - Skid captures 0x24 and the state goes to HOLD, with `imem_req`=0.
  - After release, IF/ID shows 0x24 next cycle, then fetching resumes at 0x28.
- Flush while a request to 0x30 is pending (jumpaddr=0x100):
  - The state goes to DROP and `imem_addr` stays 0x30 until ack.
  - That data is discarded, and the next fetch is at 0x100.
  - `ifid_valid`=0 in the meantime.
- Flush coincident with an ack in REQ, and flush in HOLD:
  - The ack data and the skid buffer contents never appear on IF/ID.
  - The next valid `ifid_pc` is the jump target.
- Reset asserted in DROP: all outputs return to their reset values asynchronously, and the first post-reset fetch is at PC_INIT.
